acc_writeback_unit: RTL and testbench

Drains the systolic array's accumulator bank into the dual-port RAM. It is the consumer of the WRITE_ACC_OUT instruction issued by the control FSM. On a start pulse it walks all MATRIX_SIZE² accumulators via `addr_acc`/`acc_out`, formats each result, and writes it bytewise to DPRAM port B starting at a given base address. Two formats are supported: full-width little-endian, or arithmetic-shifted and saturated to one signed byte.

---
 rtl/acc_writeback_unit.sv | 143 ++++++++++++++
 tb/tb_acc_writeback_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_writeback_unit.sv
// Drains the accumulator bank into DPRAM port B, one byte per cycle, either
// full-width little-endian or arithmetic-shifted and saturated to a signed byte.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | addr_acc presents idx to the array
// READ   | acc_out valid; first formatted byte is prepared
// WRITE  | one byte written per cycle
// DONE   | one-cycle done pulse
module acc_writeback_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int DP_ADDR_WIDTH  = 10,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DP_ADDR_WIDTH-1:0]  base_addr,
  input  logic                      sat_mode,
  input  logic [4:0]                shift,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_out,
  output logic                      we_b,
  output logic [DP_ADDR_WIDTH-1:0]  addr_b,
  output logic [DATA_WIDTH-1:0]     din_b,
  output logic                      busy,
  output logic                      done
);

  localparam int N      = MATRIX_SIZE * MATRIX_SIZE;
  localparam int B      = ACC_WIDTH / DATA_WIDTH;
  localparam int BYTE_W = $clog2(B) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX = ACC_ADDR_WIDTH'(N - 1);
  localparam logic [BYTE_W-1:0]         BYTES    = BYTE_W'(B);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-128);
  localparam logic [DATA_WIDTH-1:0] BYTE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] BYTE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]                state;
  logic [ACC_ADDR_WIDTH-1:0] idx;
  logic [DP_ADDR_WIDTH-1:0]  ptr;
  logic [ACC_WIDTH-1:0]      data_q;
  logic [BYTE_W-1:0]         byte_cnt;
  logic                      sat_q;
  logic [4:0]                shift_q;

  logic signed [ACC_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]       first_byte;
  logic [DATA_WIDTH-1:0]       next_byte;
  logic                        last_byte;

  // The first byte is formatted straight from acc_out so it can be written in
  // the cycle right after READ; later full-mode bytes come from data_q.
  always_comb begin
    shifted = $signed(acc_out) >>> shift_q;
    if (!sat_q)
      first_byte = acc_out[DATA_WIDTH-1:0];
    else if (shifted > SAT_MAX)
      first_byte = BYTE_MAX;
    else if (shifted < SAT_MIN)
      first_byte = BYTE_MIN;
    else
      first_byte = shifted[DATA_WIDTH-1:0];
    next_byte = DATA_WIDTH'(data_q >> (DATA_WIDTH * byte_cnt));
    last_byte = sat_q || (byte_cnt == BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      ptr      <= '0;
      data_q   <= '0;
      byte_cnt <= '0;
      sat_q    <= 1'b0;
      shift_q  <= '0;
      addr_acc <= '0;
      we_b     <= 1'b0;
      addr_b   <= '0;
      din_b    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      we_b <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sat_q    <= sat_mode;
            shift_q  <= shift;
            idx      <= '0;
            addr_acc <= '0;
            ptr      <= base_addr;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_READ;
        S_READ: begin
          data_q   <= acc_out;
          byte_cnt <= BYTE_W'(1);
          we_b     <= 1'b1;
          addr_b   <= ptr;
          din_b    <= first_byte;
          ptr      <= ptr + 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (!last_byte) begin
            we_b     <= 1'b1;
            addr_b   <= ptr;
            din_b    <= next_byte;
            ptr      <= ptr + 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
          end else if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            addr_acc <= idx + 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_writeback_unit.sv
// Randomized bench for acc_writeback_unit: expected DPRAM write streams and
// done latency are derived from the byte-layout and saturation rules.
module tb_acc_writeback_unit;
  localparam int N  = 64;
  localparam int B  = 4;
  localparam int AW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic        sat_mode;
  logic [4:0]  shift;
  logic [5:0]  addr_acc;
  logic [31:0] acc_out;
  logic        we_b;
  logic [9:0]  addr_b;
  logic [7:0]  din_b;
  logic        busy;
  logic        done;

  acc_writeback_unit dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .sat_mode(sat_mode), .shift(shift), .addr_acc(addr_acc), .acc_out(acc_out),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] acc_mem [N];
  int          edge_cnt = 0;
  int          done_cnt = 0;
  logic [9:0]  obs_addr [$];
  logic [7:0]  obs_data [$];
  int          exp_addr [$];
  int          exp_data [$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Accumulator bank (one-cycle read latency) and DPRAM write monitor.
  always @(posedge clk) begin
    acc_out  <= acc_mem[addr_acc];
    edge_cnt <= edge_cnt + 1;
    if (we_b) begin
      obs_addr.push_back(addr_b);
      obs_data.push_back(din_b);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, obs, expv);
    end
  endtask

  task automatic build_exp(input int base, input bit sat, input int sh);
    int v;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < N; i++) begin
      if (sat) begin
        v = $signed(acc_mem[i]) >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        exp_addr.push_back((base + i) % AW);
        exp_data.push_back(v & 255);
      end else begin
        for (int b = 0; b < B; b++) begin
          exp_addr.push_back((base + B*i + b) % AW);
          exp_data.push_back(int'((acc_mem[i] >> (8*b)) & 32'hFF));
        end
      end
    end
  endtask

  task automatic run_drain(input string tag, input int base, input bit sat,
                           input int sh, input int busy_start_at);
    int wr0, d0, t0, lat, nw;
    bit seen;
    build_exp(base, sat, sh);
    wr0 = obs_addr.size();
    d0  = done_cnt;
    @(negedge clk);
    base_addr = base[9:0];
    sat_mode  = sat;
    shift     = sh[4:0];
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    t0        = edge_cnt;
    base_addr = 10'($urandom);
    sat_mode  = !sat;
    shift     = 5'($urandom);
    check_eq({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n < 2000 && !seen; n++) begin
      start = (n == busy_start_at);
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        lat   = edge_cnt - t0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_latency"}, lat, sat ? 3*N : (2+B)*N);
    repeat (3) @(negedge clk);
    check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    nw = obs_addr.size() - wr0;
    check_eq({tag, "_writes"}, nw, exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < nw; i++) begin
      check_eq($sformatf("%s_w%0d_addr", tag, i), {22'd0, obs_addr[wr0+i]}, exp_addr[i]);
      check_eq($sformatf("%s_w%0d_data", tag, i), {24'd0, obs_data[wr0+i]}, exp_data[i]);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) acc_mem[i] = $urandom;
  endtask

  task automatic reset_mid_run();
    int wr0;
    bit hit;
    fill_random();
    wr0 = obs_addr.size();
    @(negedge clk);
    base_addr = 10'h020;
    sat_mode  = 1'b0;
    shift     = 5'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      if (obs_addr.size() - wr0 == 41) hit = 1'b1;
      else @(negedge clk);
    end
    check_eq("rst_reached_elem10", {31'd0, hit}, 32'd1);
    check_eq("rst_we_before", {31'd0, we_b}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_we_b", {31'd0, we_b}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_addr_b", {22'd0, addr_b}, 32'd0);
    check_eq("rst_din_b", {24'd0, din_b}, 32'd0);
    check_eq("rst_addr_acc", {26'd0, addr_acc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_writes_kept", obs_addr.size() - wr0, 32'd41);
    run_drain("after_rst", 10'h1C0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; sat_mode = 1'b0; shift = '0;
    for (int i = 0; i < N; i++) acc_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_we_b", {31'd0, we_b}, 32'd0);
    check_eq("reset_addr_b", {22'd0, addr_b}, 32'd0);
    check_eq("reset_din_b", {24'd0, din_b}, 32'd0);
    check_eq("reset_addr_acc", {26'd0, addr_acc}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < N; i++) acc_mem[i] = 32'h11223300 + i;
    run_drain("full_base0", 0, 1'b0, 0, 0);

    for (int i = 0; i < N; i++) acc_mem[i] = '0;
    acc_mem[0] = 32'd200;
    acc_mem[1] = -32'sd300;
    acc_mem[2] = 32'd5;
    run_drain("sat_sh0", 10'h100, 1'b1, 0, 0);

    fill_random();
    acc_mem[0] = 32'h750;
    acc_mem[1] = 32'hFFFF_FFFF;
    acc_mem[2] = 32'h7FFF_FFFF;
    run_drain("sat_sh4", $urandom_range(0, AW-1), 1'b1, 4, 0);

    fill_random();
    run_drain("wrap", 10'h3FE, 1'b0, 0, 0);

    fill_random();
    run_drain("start_busy", $urandom_range(0, AW-1), 1'b0, 0, 50);

    reset_mid_run();

    for (int r = 0; r < 4; r++) begin
      fill_random();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) acc_mem[i] = $urandom_range(0, 511) - 256;
      run_drain($sformatf("rand%0d", r), $urandom_range(0, AW-1),
                bit'($urandom_range(0, 1)), $urandom_range(0, 31), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
